alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter_pkg.sv | 19 +
 rtl/alu_core.sv | 34 +++
 rtl/defines.vh | 14 +
 rtl/alu_share_arbiter.sv | 102 ++++++++++
 tb/tb_alu_share_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and op constants for the two-requester shared ALU.
`include "defines.vh"

package alu_share_arbiter_pkg;

    localparam logic [3:0] OpAdd  = `ALU_ADD;
    localparam logic [3:0] OpSub  = `ALU_SUB;
    localparam logic [3:0] OpSll  = `ALU_SLL;
    localparam logic [3:0] OpSlt  = `ALU_SLT;
    localparam logic [3:0] OpSltu = `ALU_SLTU;
    localparam logic [3:0] OpXor  = `ALU_XOR;
    localparam logic [3:0] OpSrl  = `ALU_SRL;
    localparam logic [3:0] OpSra  = `ALU_SRA;
    localparam logic [3:0] OpOr   = `ALU_OR;
    localparam logic [3:0] OpAnd  = `ALU_AND;

    typedef enum logic {StEmpty, StFull} state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational integer ALU; unknown op encodings yield zero.
module alu_core
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            OpAdd:   result = a + b;
            OpSub:   result = a - b;
            OpSll:   result = a << shamt;
            OpSlt:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu:  result = {{(XLEN-1){1'b0}}, (a < b)};
            OpXor:   result = a ^ b;
            OpSrl:   result = a >> shamt;
            OpSra:   result = $signed(a) >>> shamt;
            OpOr:    result = a | b;
            OpAnd:   result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/defines.vh
// Shared ALUCtrl encodings: {funct7[5], funct3} of the RISC-V integer ALU ops.
`ifndef DEFINES_VH
`define DEFINES_VH
`define ALU_ADD  4'b0000
`define ALU_SLL  4'b0001
`define ALU_SLT  4'b0010
`define ALU_SLTU 4'b0011
`define ALU_XOR  4'b0100
`define ALU_SRL  4'b0101
`define ALU_OR   4'b0110
`define ALU_AND  4'b0111
`define ALU_SUB  4'b1000
`define ALU_SRA  4'b1101
`endif

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// single-entry registered response stage.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero
);

    state_e          state_q;
    logic            last_q;
    logic            grant;
    logic            can_accept;
    logic            xfer;
    logic [3:0]      op_sel;
    logic [XLEN-1:0] a_sel;
    logic [XLEN-1:0] b_sel;
    logic [XLEN-1:0] alu_res;

    // Contention goes to whoever did not win last; otherwise the sole requester.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end
    end

    // rst_n term keeps both readys low while reset is held.
    assign can_accept = rst_n && ((state_q == StEmpty) || rsp_ready);
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign op_sel = grant ? req1_op : req0_op;
    assign a_sel  = grant ? req1_a  : req0_a;
    assign b_sel  = grant ? req1_b  : req0_b;

    alu_core #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_alu_core (
        .op     (op_sel),
        .a      (a_sel),
        .b      (b_sel),
        .result (alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            last_q     <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (xfer) begin
                        state_q   <= StFull;
                        rsp_valid <= 1'b1;
                    end
                end
                StFull: begin
                    if (rsp_ready && !xfer) begin
                        state_q   <= StEmpty;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StEmpty;
                    rsp_valid <= 1'b0;
                end
            endcase
            if (xfer) begin
                rsp_id     <= grant;
                rsp_result <= alu_res;
                rsp_zero   <= (alu_res == '0);
                last_q     <= grant;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random traffic
// against a behavioural model of the arbiter and ALU.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_result;

    int checks = 0;
    int passes = 0;

    // Model: response slot contents and who won the last transfer.
    bit          m_full;
    bit          m_id;
    logic [31:0] m_result;
    bit          m_last;

    alu_share_arbiter #(
        .XLEN (32),
        .SHW  (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh = b % 32;
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpSll:   return a << sh;
            OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OpSltu:  return (a < b) ? 32'd1 : 32'd0;
            OpXor:   return a ^ b;
            OpSrl:   return a >> sh;
            OpSra:   return $signed(a) >>> sh;
            OpOr:    return a | b;
            OpAnd:   return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit exp_grant();
        if (req0_valid && req1_valid) return !m_last;
        return req1_valid;
    endfunction

    function automatic bit exp_ready(input bit who);
        bit open = rst_n && (!m_full || rsp_ready);
        if (who) return open && req1_valid && exp_grant();
        return open && req0_valid && !exp_grant();
    endfunction

    task automatic model_reset();
        m_full = 0; m_id = 0; m_result = 0; m_last = 1;
    endtask

    task automatic set_inputs(input bit v0, input logic [3:0] op0, input logic [31:0] a0,
                              input logic [31:0] b0, input bit v1, input logic [3:0] op1,
                              input logic [31:0] a1, input logic [31:0] b1, input bit rr);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready = rr;
        #1;
    endtask

    task automatic tick();
        bit g, x;
        logic [31:0] r;
        g = exp_grant();
        x = exp_ready(g) && (req0_valid || req1_valid);
        r = g ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
        @(posedge clk);
        if (x) begin
            m_full = 1; m_id = g; m_result = r; m_last = g;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(1, OpAdd, 1, 2, 1, OpAdd, 3, 4, 1);
        model_reset();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rsp_valid); else passes++;
        checks++; if (rsp_id !== 1'b0) $display("FAIL reset_id: got %b expected 0", rsp_id); else passes++;
        checks++; if (rsp_result !== 32'd0) $display("FAIL reset_result: got %h expected 0", rsp_result); else passes++;
        checks++; if (rsp_zero !== 1'b0) $display("FAIL reset_zero: got %b expected 0", rsp_zero); else passes++;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_single_add();
        set_inputs(1, OpAdd, 5, 7, 0, OpSub, 0, 0, 1);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready}); else passes++;
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL add_valid: got %b expected 1", rsp_valid); else passes++;
        checks++; if (rsp_id !== 1'b0) $display("FAIL add_id: got %b expected 0", rsp_id); else passes++;
        checks++; if (rsp_result !== 32'd12) $display("FAIL add_result: got %0d expected 12", rsp_result); else passes++;
        checks++; if (rsp_zero !== 1'b0) $display("FAIL add_zero: got %b expected 0", rsp_zero); else passes++;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL add_drain: got %b expected 0", rsp_valid); else passes++;
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_inputs(1, OpSub, 9, 9, 1, OpSlt, 32'hFFFF_FFFF, 1, 1);
            checks++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL alt_ready[%0d]: got %b", i, {req0_ready, req1_ready}); else passes++;
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2)) $display("FAIL alt_id[%0d]: got valid %b id %b expected id %0d", i, rsp_valid, rsp_id, i % 2); else passes++;
            checks++; if (rsp_result !== ((i % 2 == 0) ? 32'd0 : 32'd1)) $display("FAIL alt_result[%0d]: got %h expected %0d", i, rsp_result, i % 2); else passes++;
            checks++; if (rsp_zero !== (i % 2 == 0)) $display("FAIL alt_zero[%0d]: got %b", i, rsp_zero); else passes++;
        end
    endtask

    task automatic test_backpressure();
        set_inputs(1, OpAdd, 100, 23, 1, OpXor, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1, OpAdd, 100, 23, 1, OpXor, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 0);
            checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready}); else passes++;
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_result !== m_result) $display("FAIL bp_hold[%0d]: got v%b id%b %h expected v1 id%b %h", i, rsp_valid, rsp_id, rsp_result, m_id, m_result); else passes++;
        end
        set_inputs(1, OpAdd, 100, 23, 1, OpXor, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 1);
        checks++; if ({req0_ready, req1_ready} !== {exp_ready(0), exp_ready(1)}) $display("FAIL bp_release_ready: got %b expected %b", {req0_ready, req1_ready}, {exp_ready(0), exp_ready(1)}); else passes++;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_result !== m_result) $display("FAIL bp_next: got id%b %h expected id%b %h", rsp_id, rsp_result, m_id, m_result); else passes++;
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [3] = '{OpSra, OpSrl, OpSltu};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h21, 32'h21, 32'h1};
        logic [31:0] exp [3] = '{32'hC000_0000, 32'h4000_0000, 32'h0};
        for (int i = 0; i < 3; i++) begin
            set_inputs(0, OpAdd, 0, 0, 1, ops[i], as[i], bs[i], 1);
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== exp[i] || rsp_zero !== (exp[i] == 0)) $display("FAIL shift[%0d]: got v%b id%b %h z%b expected %h", i, rsp_valid, rsp_id, rsp_result, rsp_zero, exp[i]); else passes++;
        end
    endtask

    task automatic test_undefined();
        set_inputs(1, 4'b1111, 3, 4, 0, OpAdd, 0, 0, 1);
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) $display("FAIL undef_op: got v%b %h z%b expected v1 0 z1", rsp_valid, rsp_result, rsp_zero); else passes++;
    endtask

    task automatic test_reset_mid();
        set_inputs(1, OpAdd, 1, 2, 0, OpAdd, 0, 0, 0);
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL mid_full: got %b expected 1", rsp_valid); else passes++;
        #2;
        rst_n = 1'b0;
        model_reset();
        set_inputs(1, OpAdd, 1, 2, 1, OpAdd, 5, 6, 1);
        checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0) $display("FAIL mid_drop: got v%b %h expected v0 0", rsp_valid, rsp_result); else passes++;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mid_ready: got %b expected 00", {req0_ready, req1_ready}); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_stale: got %b expected 0", rsp_valid); else passes++;
        set_inputs(1, OpAdd, 1, 2, 1, OpAdd, 5, 6, 1);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mid_first_grant: got %b expected 10", {req0_ready, req1_ready}); else passes++;
        tick();
        checks++; if (rsp_id !== 1'b0 || rsp_result !== 32'd3) $display("FAIL mid_first_rsp: got id%b %h expected id0 3", rsp_id, rsp_result); else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_inputs(($urandom % 4) != 0, 4'($urandom), $urandom, ($urandom % 2) ? $urandom : 32'($urandom % 40),
                       ($urandom % 4) != 0, 4'($urandom), $urandom, ($urandom % 2) ? $urandom : 32'($urandom % 40),
                       ($urandom % 3) != 0);
            checks++; if ({req0_ready, req1_ready} !== {exp_ready(0), exp_ready(1)}) $display("FAIL rnd_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, {exp_ready(0), exp_ready(1)}); else passes++;
            tick();
            checks++;
            if (rsp_valid !== m_full || (m_full && (rsp_id !== m_id || rsp_result !== m_result || rsp_zero !== (m_result == 0))))
                $display("FAIL rnd_rsp[%0d]: got v%b id%b %h z%b expected v%b id%b %h", i, rsp_valid, rsp_id, rsp_result, rsp_zero, m_full, m_id, m_result);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_alternate();
        test_backpressure();
        test_shifts();
        test_undefined();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
